// File: rtl/c2h_arbiter_pkg.sv
// Shared types and constants for the C2H stream arbiter and its output skid stage.
package c2h_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  localparam int PACKET_COUNT_WIDTH = 32;
  localparam int BEAT_DATA_WIDTH    = 64;

  typedef struct packed {
    logic [BEAT_DATA_WIDTH-1:0]   tdata;
    logic [BEAT_DATA_WIDTH/8-1:0] tkeep;
    logic                         tlast;
  } axis_beat_t;

  // Round-robin successor of a source index, wrapping at num_sources.
  function automatic int next_source(input int idx, input int num_sources);
    return (idx + 1 >= num_sources) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXIS register slice: output register plus one skid entry, so the
// upstream ready is a flop and full throughput is kept when downstream is ready.
module axis_skid_buffer
  import c2h_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic [KEEP_WIDTH-1:0] s_tkeep,
  input  logic                  s_tlast,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready
);

  localparam int BEAT_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1;

  logic [BEAT_WIDTH-1:0] in_beat;
  logic [BEAT_WIDTH-1:0] out_beat_q, out_beat_d;
  logic [BEAT_WIDTH-1:0] skid_beat_q, skid_beat_d;
  logic                  out_valid_q, out_valid_d;
  logic                  skid_valid_q, skid_valid_d;

  assign in_beat  = {s_tdata, s_tkeep, s_tlast};
  assign s_tready = !skid_valid_q;

  // The skid entry only fills when a beat arrives while the output is stalled.
  always_comb begin
    out_beat_d   = out_beat_q;
    out_valid_d  = out_valid_q;
    skid_beat_d  = skid_beat_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || m_tready) begin
      if (skid_valid_q) begin
        out_beat_d   = skid_beat_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = s_tvalid;
        if (s_tvalid) begin
          out_beat_d = in_beat;
        end
      end
    end else if (s_tvalid && !skid_valid_q) begin
      skid_beat_d  = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_beat_q   <= '0;
      out_valid_q  <= 1'b0;
      skid_beat_q  <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_beat_q   <= out_beat_d;
      out_valid_q  <= out_valid_d;
      skid_beat_q  <= skid_beat_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign {m_tdata, m_tkeep, m_tlast} = out_beat_q;
  assign m_tvalid = out_valid_q;

endmodule

// File: rtl/c2h_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXIS C2H stream between
// several producers; a grant is held from the first beat until tlast is accepted.
module c2h_stream_arbiter
  import c2h_arbiter_pkg::*;
#(
  parameter  int NUM_SOURCES = 2,
  parameter  int DATA_WIDTH  = 64,
  parameter  int KEEP_WIDTH  = DATA_WIDTH / 8,
  localparam int GRANT_WIDTH = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              enable,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_SOURCES*KEEP_WIDTH-1:0] s_tkeep,
  input  logic [NUM_SOURCES-1:0]            s_tlast,
  input  logic [NUM_SOURCES-1:0]            s_tvalid,
  output logic [NUM_SOURCES-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]             m_tdata,
  output logic [KEEP_WIDTH-1:0]             m_tkeep,
  output logic                              m_tlast,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic                              busy,
  output logic [GRANT_WIDTH-1:0]            grant_id,
  output logic [PACKET_COUNT_WIDTH-1:0]     packet_count
);

  arb_state_t                    state_q, state_d;
  logic [GRANT_WIDTH-1:0]        grant_q, grant_d;
  logic [GRANT_WIDTH-1:0]        rr_q, rr_d;
  logic [PACKET_COUNT_WIDTH-1:0] packet_count_q, packet_count_d;

  logic [2*NUM_SOURCES-1:0] req_rotated;
  logic                     found;
  int                       cand;
  logic [DATA_WIDTH-1:0]    sel_tdata;
  logic [KEEP_WIDTH-1:0]    sel_tkeep;
  logic                     sel_tlast;
  logic                     sel_tvalid;
  logic                     skid_s_tvalid;
  logic                     skid_s_tready;

  // Steer the granted source's beat towards the skid stage.
  always_comb begin
    sel_tdata  = '0;
    sel_tkeep  = '0;
    sel_tlast  = 1'b0;
    sel_tvalid = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (grant_q == GRANT_WIDTH'(i)) begin
        sel_tdata  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_tkeep  = s_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_tlast  = s_tlast[i];
        sel_tvalid = s_tvalid[i];
      end
    end
  end

  // Requests are rotated so the search starts at the round-robin pointer.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    found         = 1'b0;
    cand          = 0;
    s_tready      = '0;
    skid_s_tvalid = 1'b0;
    req_rotated   = {s_tvalid, s_tvalid} >> rr_q;
    case (state_q)
      ARB_IDLE: begin
        if (enable && |s_tvalid) begin
          for (int k = 0; k < NUM_SOURCES; k++) begin
            if (!found && req_rotated[k]) begin
              found = 1'b1;
              cand  = int'(rr_q) + k;
              if (cand >= NUM_SOURCES) cand = cand - NUM_SOURCES;
              grant_d = GRANT_WIDTH'(cand);
            end
          end
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        for (int i = 0; i < NUM_SOURCES; i++) begin
          if (grant_q == GRANT_WIDTH'(i)) s_tready[i] = skid_s_tready;
        end
        skid_s_tvalid = sel_tvalid;
        if (sel_tvalid && skid_s_tready && sel_tlast) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          rr_d    = GRANT_WIDTH'(next_source(int'(grant_q), NUM_SOURCES));
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    packet_count_d = packet_count_q;
    if (m_tvalid && m_tready && m_tlast) begin
      packet_count_d = packet_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ARB_IDLE;
      grant_q        <= '0;
      rr_q           <= '0;
      packet_count_q <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      rr_q           <= rr_d;
      packet_count_q <= packet_count_d;
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH)
  ) u_out_skid (
    .clock    (clock),
    .reset_n  (reset_n),
    .s_tdata  (sel_tdata),
    .s_tkeep  (sel_tkeep),
    .s_tlast  (sel_tlast),
    .s_tvalid (skid_s_tvalid),
    .s_tready (skid_s_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tlast  (m_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready)
  );

  assign busy         = (state_q == ARB_LOCKED);
  assign grant_id     = grant_q;
  assign packet_count = packet_count_q;

endmodule
